// File: rtl/ser_pkg.sv
// Shared constants, types and helpers for the ser endpoint (far-end partner of the des lane bridge).
package ser_pkg;

  localparam int NSLICE    = 4;
  localparam int FRAME_LEN = 2 * NSLICE;
  localparam int TX_LANE_W = 13;
  localparam int RX_LANE_W = 16;
  localparam int TX_WORD_W = TX_LANE_W * NSLICE;
  localparam int RX_WORD_W = RX_LANE_W * NSLICE;
  localparam int PHASE_W   = $clog2(FRAME_LEN);
  localparam int SLICE_W   = $clog2(NSLICE);

  typedef logic [PHASE_W-1:0] phase_t;
  typedef logic [SLICE_W-1:0] slice_t;

  localparam phase_t PHASE_FIRST = phase_t'(0);
  localparam phase_t PHASE_LAST  = phase_t'(FRAME_LEN - 1);
  localparam phase_t PHASE_RXEND = phase_t'(NSLICE - 1);

  typedef enum logic {
    ST_UNLOCKED = 1'b0,
    ST_LOCKED   = 1'b1
  } lock_state_e;

  // Lane slices travel in the first half of the frame; the second half is idle.
  function automatic logic is_slice_phase(input phase_t p);
    return (p < phase_t'(NSLICE));
  endfunction

endpackage

// File: rtl/ser_if.sv
// Lane and word-handshake signals between the ser endpoint and its environment.
interface ser_if;
  import ser_pkg::*;

  logic                 ser_sync_in;
  logic [TX_WORD_W-1:0] ser_din;
  logic                 ser_din_valid;
  logic                 ser_din_ready;
  logic [TX_LANE_W-1:0] ser_sout;
  logic [RX_LANE_W-1:0] ser_sin;
  logic [RX_WORD_W-1:0] ser_dout;
  logic                 ser_dout_valid;
  logic                 ser_locked;
  logic                 ser_align_err;

  modport slave (
    input  ser_sync_in, ser_din, ser_din_valid, ser_sin,
    output ser_din_ready, ser_sout, ser_dout, ser_dout_valid, ser_locked, ser_align_err
  );

  modport master (
    output ser_sync_in, ser_din, ser_din_valid, ser_sin,
    input  ser_din_ready, ser_sout, ser_dout, ser_dout_valid, ser_locked, ser_align_err
  );

endinterface

// File: rtl/ser_phase_tracker.sv
// Recovers the frame phase from the des frame clock, tracks lock and flags misaligned sync edges.
module ser_phase_tracker
  import ser_pkg::*;
(
  input  logic   in_clk,
  input  logic   rst,
  input  logic   sync_in,
  output phase_t phase,
  output logic   locked,
  output logic   misalign,
  output logic   align_err
);

  logic        sync_q;
  logic        rise;
  phase_t      phase_q;
  lock_state_e state_q;
  lock_state_e state_d;

  // A rising frame clock forces phase 0 in the same cycle, so the lane mux sees it without delay.
  assign rise     = sync_in & ~sync_q;
  assign phase    = rise ? PHASE_FIRST : phase_q;
  assign locked   = (state_q == ST_LOCKED);
  assign misalign = locked & rise & (phase_q != PHASE_FIRST);

  // Delayed copy of the frame clock for edge detection.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) sync_q <= 1'b0;
    else     sync_q <= sync_in;
  end

  // Phase counter wraps mod 8 and realigns to 1 after every rise.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) phase_q <= PHASE_LAST;
    else     phase_q <= phase + phase_t'(1);
  end

  // Lock state register.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) state_q <= ST_UNLOCKED;
    else     state_q <= state_d;
  end

  // Lock is acquired on the first rise and only lost through reset.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_UNLOCKED: if (rise) state_d = ST_LOCKED;
      ST_LOCKED:   state_d = ST_LOCKED;
      default:     state_d = ST_UNLOCKED;
    endcase
  end

  // Sticky alignment error; only reset clears it.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst)           align_err <= 1'b0;
    else if (misalign) align_err <= 1'b1;
  end

endmodule

// File: rtl/ser_endpoint.sv
// Far-end lane endpoint: slices 52-bit TX words onto the 13-bit lane and rebuilds 64-bit RX words.
module ser_endpoint
  import ser_pkg::*;
(
  input  logic in_clk,
  input  logic rst,
  ser_if.slave bus
);

  phase_t phase;
  slice_t slice_idx;
  logic   locked;
  logic   misalign;
  logic   align_err;
  logic   frame_end;

  logic                 ready;
  logic                 accept;
  logic [TX_WORD_W-1:0] pend_q;
  logic                 pend_full_q;
  logic [TX_WORD_W-1:0] active_q;
  logic [TX_LANE_W-1:0] sout;

  logic                           rx_capture;
  logic [RX_WORD_W-RX_LANE_W-1:0] rx_part_q;
  logic                           frame_ok_q;
  logic [RX_WORD_W-1:0]           dout_q;
  logic                           dout_valid_q;

  ser_phase_tracker u_tracker (
    .in_clk    (in_clk),
    .rst       (rst),
    .sync_in   (bus.ser_sync_in),
    .phase     (phase),
    .locked    (locked),
    .misalign  (misalign),
    .align_err (align_err)
  );

  assign slice_idx  = phase[SLICE_W-1:0];
  assign frame_end  = (phase == PHASE_LAST);
  assign ready      = locked & (~pend_full_q | frame_end);
  assign accept     = bus.ser_din_valid & ready;
  assign rx_capture = locked & ~misalign & is_slice_phase(phase);

  // Pending slot: refilled on accept; at frame end it drains and may refill in the same edge.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      pend_q      <= '0;
      pend_full_q <= 1'b0;
    end else if (frame_end) begin
      pend_q      <= accept ? bus.ser_din : '0;
      pend_full_q <= accept;
    end else if (accept) begin
      pend_q      <= bus.ser_din;
      pend_full_q <= 1'b1;
    end
  end

  // Active word is loaded at frame end and dropped when the frame is realigned.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst)            active_q <= '0;
    else if (misalign)  active_q <= '0;
    else if (frame_end) active_q <= pend_full_q ? pend_q : '0;
  end

  // Outbound lane mux: one slice per cycle in phases 0-3, silent otherwise or while realigning.
  always_comb begin
    sout = '0;
    if (locked && !misalign && is_slice_phase(phase)) begin
      for (int s = 0; s < NSLICE; s++) begin
        if (slice_idx == s[SLICE_W-1:0]) sout = active_q[s*TX_LANE_W +: TX_LANE_W];
      end
    end
  end

  // RX assembler: slices 0-2 are buffered, slice 3 goes straight into the output word.
  always_ff @(posedge in_clk or posedge rst) begin
    if (rst) begin
      rx_part_q    <= '0;
      frame_ok_q   <= 1'b0;
      dout_q       <= '0;
      dout_valid_q <= 1'b0;
    end else begin
      dout_valid_q <= 1'b0;
      if (misalign) begin
        rx_part_q  <= '0;
        frame_ok_q <= 1'b0;
      end else if (rx_capture) begin
        for (int s = 0; s < NSLICE - 1; s++) begin
          if (slice_idx == s[SLICE_W-1:0]) rx_part_q[s*RX_LANE_W +: RX_LANE_W] <= bus.ser_sin;
        end
        if (phase == PHASE_FIRST) frame_ok_q <= 1'b1;
        if (phase == PHASE_RXEND) begin
          frame_ok_q <= 1'b0;
          if (frame_ok_q) begin
            dout_q       <= {bus.ser_sin, rx_part_q};
            dout_valid_q <= 1'b1;
          end
        end
      end
    end
  end

  assign bus.ser_din_ready  = ready;
  assign bus.ser_sout       = sout;
  assign bus.ser_dout       = dout_q;
  assign bus.ser_dout_valid = dout_valid_q;
  assign bus.ser_locked     = locked;
  assign bus.ser_align_err  = align_err;

endmodule
